// File: rtl/tile_scheduler.sv
// tile_scheduler: sweeps an (i_last+1) x (j_last+1) tile grid row-major, one tile at a time.
// Define TILE_SCHED_TIMEOUT_EN to add a per-tile tp_done timeout of TIMEOUT_CYCLES WAIT cycles.
module tile_scheduler #(
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [2:0] cmd_op,
   input  logic [2:0] cmd_i_last,
   input  logic [2:0] cmd_j_last,
   input  logic       abort,
   output logic       tp_start,
   output logic [2:0] tp_tile_i,
   output logic [2:0] tp_tile_j,
   output logic [2:0] tp_op_code,
   input  logic       tp_done,
   output logic       busy,
   output logic       sched_done,
   output logic       err_opcode,
   output logic       err_timeout,
   output logic       aborted,
   output logic [6:0] tiles_done,
   output logic [1:0] dbg_state
);

   // Command handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
   // cmd_ready is high only in IDLE, so a command offered while busy is held off, not dropped.
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FINISH} state_t;

   state_t     state;
   logic [2:0] i_last;
   logic [2:0] j_last;
   logic       abort_pend;
   logic       first_wait;
   logic       tile_is_last;

   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 2");
   end

   assign cmd_ready    = (state == IDLE);
   assign busy         = (state != IDLE);
   assign dbg_state    = state;
   assign tile_is_last = (tp_tile_i == i_last) && (tp_tile_j == j_last);

`ifdef TILE_SCHED_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
   logic [CNT_W-1:0] wait_cnt;
`else
   assign err_timeout = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         tp_start   <= 1'b0;
         tp_tile_i  <= 3'd0;
         tp_tile_j  <= 3'd0;
         tp_op_code <= 3'd0;
         i_last     <= 3'd0;
         j_last     <= 3'd0;
         sched_done <= 1'b0;
         err_opcode <= 1'b0;
         aborted    <= 1'b0;
         tiles_done <= 7'd0;
         abort_pend <= 1'b0;
         first_wait <= 1'b0;
`ifdef TILE_SCHED_TIMEOUT_EN
         err_timeout <= 1'b0;
         wait_cnt    <= '0;
`endif
      end else begin
         tp_start   <= 1'b0;
         sched_done <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  tp_op_code <= cmd_op;
                  i_last     <= cmd_i_last;
                  j_last     <= cmd_j_last;
                  tp_tile_i  <= 3'd0;
                  tp_tile_j  <= 3'd0;
                  tiles_done <= 7'd0;
                  aborted    <= 1'b0;
                  abort_pend <= 1'b0;
`ifdef TILE_SCHED_TIMEOUT_EN
                  err_timeout <= 1'b0;
`endif
                  if (cmd_op > 3'd4) begin
                     err_opcode <= 1'b1;
                     state      <= FINISH;
                  end else begin
                     err_opcode <= 1'b0;
                     tp_start   <= 1'b1;
                     state      <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               if (abort) begin
                  abort_pend <= 1'b1;
                  aborted    <= 1'b1;
               end
               first_wait <= 1'b1;
`ifdef TILE_SCHED_TIMEOUT_EN
               wait_cnt <= '0;
`endif
               state <= WAIT;
            end
            WAIT: begin
               first_wait <= 1'b0;
               if (abort) begin
                  abort_pend <= 1'b1;
                  aborted    <= 1'b1;
               end
               // The first WAIT cycle cannot carry a real completion for this tile.
               if (tp_done && !first_wait) begin
                  tiles_done <= tiles_done + 7'd1;
                  if (tile_is_last || abort_pend || abort) begin
                     state <= FINISH;
                  end else begin
                     if (tp_tile_j == j_last) begin
                        tp_tile_j <= 3'd0;
                        tp_tile_i <= tp_tile_i + 3'd1;
                     end else begin
                        tp_tile_j <= tp_tile_j + 3'd1;
                     end
                     tp_start <= 1'b1;
                     state    <= ISSUE;
                  end
               end
`ifdef TILE_SCHED_TIMEOUT_EN
               else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  err_timeout <= 1'b1;
                  state       <= FINISH;
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
`endif
            end
            FINISH: begin
               sched_done <= 1'b1;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tile_scheduler.sv
// Bench for tile_scheduler: randomized sweeps against a grid-level reference model,
// with a tile-processor model answering tp_start and a scoreboard monitor.
module tb_tile_scheduler;

   localparam int TO_CYCLES = 16;
`ifdef TILE_SCHED_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [2:0] cmd_op;
   logic [2:0] cmd_i_last;
   logic [2:0] cmd_j_last;
   logic       abort;
   logic       tp_start;
   logic [2:0] tp_tile_i;
   logic [2:0] tp_tile_j;
   logic [2:0] tp_op_code;
   logic       tp_done;
   logic       busy;
   logic       sched_done;
   logic       err_opcode;
   logic       err_timeout;
   logic       aborted;
   logic [6:0] tiles_done;
   logic [1:0] dbg_state;

   logic tp_done_m = 1'b0;
   logic abort_m = 1'b0;
   logic noise_done = 1'b0;
   logic noise_abort = 1'b0;
   assign tp_done = tp_done_m | noise_done;
   assign abort   = abort_m | noise_abort;

   tile_scheduler #(.TIMEOUT_CYCLES(TO_CYCLES)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_i_last(cmd_i_last), .cmd_j_last(cmd_j_last),
      .abort(abort), .tp_start(tp_start), .tp_tile_i(tp_tile_i),
      .tp_tile_j(tp_tile_j), .tp_op_code(tp_op_code), .tp_done(tp_done),
      .busy(busy), .sched_done(sched_done), .err_opcode(err_opcode),
      .err_timeout(err_timeout), .aborted(aborted), .tiles_done(tiles_done),
      .dbg_state(dbg_state)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   // mode: 0 done 2 cycles after start, 1 random 2..6 with a first-WAIT glitch,
   //       2 done 10 cycles after start, 3 done 20 cycles after start
   typedef struct {
      int abort_tile;
      int abort_at_done;
      int mode;
      int m;
   } cfg_t;

   cfg_t        cfg_q[$];
   cfg_t        cur;
   int          cmd_seq = 0;
   logic [8:0]  exp_start_q[$];
   logic [12:0] exp_res_q[$];
   logic [8:0]  exp_s;
   logic [12:0] exp_r;
   int          n_cmp = 0;
   int          n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (!rst) begin
         check("ready_vs_busy", cmd_ready, !busy);
         if (tp_start) begin
            if (exp_start_q.size() == 0) begin
               check("unexpected_start", {tp_op_code, tp_tile_i, tp_tile_j}, 32'hFFFF_FFFF);
            end else begin
               exp_s = exp_start_q.pop_front();
               check("tile_start", {tp_op_code, tp_tile_i, tp_tile_j}, exp_s);
            end
         end
         if (sched_done) begin
            if (exp_res_q.size() == 0) begin
               check("unexpected_sched_done", 1'b1, 1'b0);
            end else begin
               exp_r = exp_res_q.pop_front();
               check("sweep_result",
                     {tp_op_code, tiles_done, err_opcode, err_timeout, aborted}, exp_r);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && cmd_valid && cmd_ready) begin
         if (cfg_q.size() != 0) cur = cfg_q.pop_front();
         cmd_seq++;
      end
   end

   // ---------------- tile processor model ----------------
   initial begin : tp_model
      int d, a, seen_seq, tcnt;
      bit ab, gl, last, fin;
      seen_seq = 0;
      tcnt = 0;
      forever begin
         step();
         while (tp_start && !rst) begin
            if (seen_seq != cmd_seq) begin
               seen_seq = cmd_seq;
               tcnt = 0;
            end
            case (cur.mode)
               0:       d = 2;
               1:       d = $urandom_range(2, 6);
               2:       d = 10;
               default: d = 20;
            endcase
            ab   = (tcnt == cur.abort_tile);
            a    = cur.abort_at_done ? d : $urandom_range(0, d);
            gl   = (cur.mode == 1) && (d >= 3) && ($urandom_range(0, 1) == 1);
            last = (tcnt == cur.m - 1);
            fin  = last && (cur.abort_tile < 0) && (cur.mode <= 1) && ($urandom_range(0, 1) == 1);
            for (int c = 0; c <= d; c++) begin
               tp_done_m = (c == d) || (gl && c == 1);
               abort_m   = ab && (c == a);
               step();
               tp_done_m = 1'b0;
               abort_m   = 1'b0;
            end
            tcnt++;
            check("start_after_done", tp_start, tcnt < cur.m);
            if (fin) begin
               // abort landing in the FINISH cycle must not mark the sweep
               abort_m = 1'b1;
               step();
               abort_m = 1'b0;
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic issue(input logic [2:0] op, input logic [2:0] il, input logic [2:0] jl);
      int guard;
      guard = 0;
      cmd_op = op;
      cmd_i_last = il;
      cmd_j_last = jl;
      cmd_valid = 1'b1;
      while (!cmd_ready && guard < 3000) begin
         step();
         guard++;
      end
      if (!cmd_ready) begin
         check("cmd_accept_timeout", 1'b0, 1'b1);
         cmd_valid = 1'b0;
         return;
      end
      step();
      cmd_valid = 1'b0;
      cmd_op = 3'($urandom_range(0, 7));
      cmd_i_last = 3'($urandom_range(0, 7));
      cmd_j_last = 3'($urandom_range(0, 7));
      check("start_after_accept", tp_start, op <= 3'd4);
      check("busy_after_accept", busy, 1'b1);
   endtask

   task automatic wait_idle();
      int guard;
      guard = 0;
      while (busy && guard < 3000) begin
         step();
         guard++;
      end
      if (busy) check("sweep_timeout", 1'b1, 1'b0);
   endtask

   // Reference model: which tiles a sweep issues and how it ends, from the grid rules alone.
   task automatic run(input logic [2:0] op, input logic [2:0] il, input logic [2:0] jl,
                      input int abort_tile, input int abort_at_done, input int mode);
      cfg_t c;
      int   n, m, td, cols;
      bit   to, ab;
      cols = int'(jl) + 1;
      n = (int'(il) + 1) * cols;
      to = 1'b0;
      if (op > 3'd4) m = 0;
      else if (abort_tile >= 0) m = abort_tile + 1;
      else m = n;
      td = m;
      if (TO_EN && mode == 3 && op <= 3'd4) begin
         m = 1;
         td = 0;
         to = 1'b1;
      end
      ab = (abort_tile >= 0) && (op <= 3'd4);
      for (int t = 0; t < m; t++)
         exp_start_q.push_back({op, 3'(t / cols), 3'(t % cols)});
      exp_res_q.push_back({op, 7'(td), op > 3'd4, to, ab});
      c.abort_tile = (op <= 3'd4) ? abort_tile : -1;
      c.abort_at_done = abort_at_done;
      c.mode = mode;
      c.m = m;
      cfg_q.push_back(c);
      issue(op, il, jl);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int n, ab;
      logic [2:0] op, il, jl;
      cur = '{abort_tile: -1, abort_at_done: 0, mode: 0, m: 0};
      rst = 1'b1;
      cmd_valid = 1'b0;
      cmd_op = 3'd0;
      cmd_i_last = 3'd0;
      cmd_j_last = 3'd0;
      repeat (3) step();
      check("reset_outputs",
            {cmd_ready, busy, tp_start, tp_tile_i, tp_tile_j, tp_op_code, sched_done,
             err_opcode, err_timeout, aborted, tiles_done, dbg_state}, {1'b1, 24'd0});
      rst = 1'b0;
      step();
      check("ready_after_reset", cmd_ready, 1'b1);

      // 2x2 sweep, done 20 cycles after each start (only meaningful without the timeout)
      if (!TO_EN) begin
         run(3'd0, 3'd1, 3'd1, -1, 0, 3);
         wait_idle();
      end

      // full 8x8 sweep with the fastest acceptable tile processor
      run(3'd4, 3'd7, 3'd7, -1, 0, 0);
      wait_idle();
      step();
      check("tiles_done_64", tiles_done, 7'd64);

      // tp_done and abort while idle are ignored
      noise_done = 1'b1;
      noise_abort = 1'b1;
      step();
      noise_done = 1'b0;
      noise_abort = 1'b0;
      repeat (3) step();
      check("idle_abort_ignored", aborted, 1'b0);
      check("idle_done_ignored", tiles_done, 7'd64);
      check("idle_not_busy", busy, 1'b0);

      // bad opcode: sched_done two cycles after accept, no tiles
      run(3'd6, 3'd2, 3'd2, -1, 0, 0);
      check("bad_op_finish_cycle", sched_done, 1'b0);
      step();
      check("bad_op_sched_done", sched_done, 1'b1);
      check("bad_op_err", err_opcode, 1'b1);
      step();
      check("sched_done_one_cycle", sched_done, 1'b0);

      // abort during tile (0,1) of a 4-tile sweep
      run(3'd1, 3'd1, 3'd1, 1, 0, 1);
      wait_idle();
      // abort together with the last tile's tp_done
      run(3'd2, 3'd1, 3'd2, 5, 1, 0);
      wait_idle();
      // single tile
      run(3'd3, 3'd0, 3'd0, -1, 0, 1);
      wait_idle();
      // back-to-back: second command held off while busy
      run(3'd0, 3'd0, 3'd2, -1, 0, 0);
      run(3'd1, 3'd1, 3'd0, -1, 0, 1);
      wait_idle();

      for (int k = 0; k < 14; k++) begin
         op = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
         il = 3'($urandom_range(0, 3));
         jl = 3'($urandom_range(0, 3));
         n = (int'(il) + 1) * (int'(jl) + 1);
         ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
         run(op, il, jl, ab, $urandom_range(0, 1), $urandom_range(0, 1));
         if ($urandom_range(0, 2) != 0) wait_idle();
      end
      wait_idle();

      // reset in the middle of WAIT abandons the sweep silently
      step();
      cfg_q.push_back('{abort_tile: -1, abort_at_done: 0, mode: 2, m: 1});
      exp_start_q.push_back({3'd2, 3'd0, 3'd0});
      issue(3'd2, 3'd1, 3'd1);
      repeat (4) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rst_mid_busy", busy, 1'b0);
      check("rst_mid_ready", cmd_ready, 1'b1);
      check("rst_mid_flags", {err_opcode, err_timeout, aborted, sched_done, tiles_done}, 11'd0);
      step();
      check("rst_mid_no_done", sched_done, 1'b0);
      repeat (15) step();
      run(3'd4, 3'd0, 3'd1, -1, 0, 0);
      wait_idle();

`ifdef TILE_SCHED_TIMEOUT_EN
      // tile processor answers only after the timeout has fired
      run(3'd3, 3'd1, 3'd1, -1, 0, 3);
      wait_idle();
      repeat (6) step();
      check("timeout_flag", err_timeout, 1'b1);
      check("timeout_tiles", tiles_done, 7'd0);
      check("late_done_ignored", busy, 1'b0);
`else
      check("no_timeout_flag", err_timeout, 1'b0);
`endif

      repeat (5) step();
      check("start_queue_drained", exp_start_q.size(), 0);
      check("result_queue_drained", exp_res_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
